fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  IF stage: owns the PC, issues instruction fetches to the per-core I-cache port
//  (req/gnt + rvalid, one request outstanding) and delivers {pc, instr} to IF/ID.
//  Consumes br_taken/br_target from the EX-stage branch_condition + ALU. Redirects the PC,
//  squashes wrong-path fetches and flushes IF/ID. A 1-entry skid buffer absorbs responses under stall.
// PARAMETERS
//  XLEN     32            address/PC width
//  RESET_PC 32'h0000_0000 first fetch address after reset (bits [1:0] must be 0)
// PORTS
//  clk         in  1     single clock, rising edge
//  rst_n       in  1     asynchronous, active-low reset
//  br_taken    in  1     EX: branch/JAL taken (branch_condition output)
//  br_target   in  XLEN  EX: redirect address; bits [1:0] ignored, forced 0
//  stall       in  1     hazard unit: hold IF/ID contents
//  imem_req    out 1     fetch request valid
//  imem_addr   out XLEN  fetch address, word aligned
//  imem_gnt    in  1     request accepted this cycle (handshake = req & gnt)
//  imem_rvalid in  1     response valid, exactly 1 per granted request, >=1 cycle after gnt
//  imem_rdata  in  32    response instruction
//  if_valid    out 1     IF/ID holds a valid instruction
//  if_pc       out XLEN  PC of if_instr
//  if_instr    out 32    fetched instruction
//  flush       out 1     kill younger IF/ID, ID/EX (= br_taken, combinational)
// BEHAVIOUR
//  Reset (async): state=IDLE, pc=RESET_PC, imem_req=0, if_valid=0, if_pc=0, if_instr=32'h0000_0013 (NOP),
//   skid empty. The first clock edge after rst_n deassertion moves the FSM from IDLE to FETCH.
//  States: IDLE, FETCH, WAIT, DRAIN.
//   IDLE -> FETCH unconditionally.
//   FETCH: imem_req = !skid_full; imem_addr = pc. On req&gnt: pc <= pc+4 (wraps mod 2^XLEN); -> WAIT.
//   WAIT: imem_req=0. On rvalid, capture {addr_of_req, rdata} and go -> FETCH.
//   DRAIN: imem_req=0. Discard the next rvalid, then -> FETCH.
//  Redirect (br_taken=1), highest priority after reset, applied at the clock edge:
//   pc <= {br_target[XLEN-1:2],2'b00}; if_valid <= 0; skid cleared.
//   The next FSM state depends on the current state and handshake:
//    FETCH without gnt -> stays in FETCH, retargets imem_addr (the only permitted address change while req=1).
//    FETCH with gnt, or WAIT without rvalid -> DRAIN.
//    WAIT with rvalid -> the response is dropped; -> FETCH.
//    IDLE/DRAIN -> unchanged FSM transition.
//   flush=br_taken in the same cycle. br_taken on consecutive cycles: last target wins.
//  Delivery (no redirect):
//   IF/ID loads when !if_valid | !stall, with source priority: skid, then live response, else if_valid <= 0.
//   A live response with IF/ID loadable and skid empty goes straight to IF/ID.
//   A response under stall with if_valid=1 goes into the skid.
//   Skid full blocks new requests, so there is never an overflow.
//  Latency: gnt at cycle t, rvalid at t+k -> if_valid at t+k+1 (no stall).
//   Back-to-back throughput 1 instr / 2 cycles.
//  stall together with br_taken: redirect wins (stall ignored that cycle).
//  Reset mid-transaction: state is lost; the I-cache is reset by the same rst_n, so no stale rvalid.
// STRUCTURE
//  riscv_pkg: XLEN, OPC_JAL=7'b1101111, OPC_BRANCH=7'b1100011, NOP_INSTR, typedef enum logic[1:0] fetch_state_t.
//  Sub-module fetch_skid_buffer (1 entry: push, pop, flush, full, {pc,instr}).
//  The FSM, PC and IF/ID register are in fetch_unit.
//  SVA: imem_addr stable while req&!gnt except on br_taken; no rvalid in FETCH/IDLE.
// TESTING
//  1 Reset: rst_n low mid-cycle -> outputs at reset values immediately.
//    Release -> req=1, addr=0 after 1 edge.
//  2 Streaming: gnt=1, rvalid 1 cycle later, rdata=addr^32'hA5A5_0000 ->
//    IF/ID sees pc 0,4,8,... in order, no gaps beyond 2-cycle cadence.
//  3 Stall: stall=1 for 5 cycles with a response arriving -> IF/ID holds,
//    skid full, req=0. Release -> skid instr delivered next edge, then fetch resumes.
//  4 Redirect in WAIT: br_taken with target 32'h0000_0103 ->
//    flush=1, if_valid=0 next, DRAIN discards the old rvalid, next req addr=32'h100.
//  5 Redirect in FETCH with gnt=0 -> same cycle+1 addr=target, no DRAIN, pc after gnt = target+4.
//  6 Random stall/gnt/rvalid delays (0-7 cycles) vs. golden PC model, 10k cycles, scoreboard {pc,instr}.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 core definitions: widths, opcodes of interest to the front end,
// and the fetch FSM state encoding.
package riscv_pkg;

  localparam int          XLEN       = 32;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_DRAIN
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding slot for a fetch response that arrives while IF/ID is stalled.
// Push wins over pop so a same-cycle pop/push replaces the entry.
module fetch_skid_buffer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic            flush,
  input  logic [XLEN-1:0] push_pc,
  input  logic [31:0]     push_instr,
  output logic            full,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     instr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
    end else if (flush) begin
      full <= 1'b0;
    end else if (push) begin
      full <= 1'b1;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

  // Payload is only meaningful while full, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      pc    <= push_pc;
      instr <= push_instr;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, runs the single-outstanding I-cache fetch handshake,
// and fills the IF/ID register, redirecting and squashing on taken branches.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr,
  output logic            flush
);

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_pc;
  logic            hs;
  logic            live;
  logic            load_en;
  logic            skid_full;
  logic            skid_push;
  logic            skid_pop;
  logic [XLEN-1:0] skid_pc;
  logic [31:0]     skid_instr;
  logic            unused_br_lsb;

  assign hs            = imem_req & imem_gnt;
  assign live          = (state == ST_WAIT) & imem_rvalid & ~br_taken;
  assign load_en       = ~if_valid | ~stall;
  assign flush         = br_taken;
  assign skid_pop      = load_en & skid_full & ~br_taken;
  // A live response parks in the skid when IF/ID cannot take it or the skid has priority.
  assign skid_push     = live & (~load_en | skid_full);
  assign unused_br_lsb = ^br_target[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  state_nxt = ST_FETCH;
      ST_FETCH: if (hs) state_nxt = br_taken ? ST_DRAIN : ST_WAIT;
      ST_WAIT: begin
        if (imem_rvalid)   state_nxt = ST_FETCH;
        else if (br_taken) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: if (imem_rvalid) state_nxt = ST_FETCH;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc;
    if (state == ST_FETCH) imem_req = ~skid_full;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (br_taken) begin
      pc <= {br_target[XLEN-1:2], 2'b00};
    end else if (hs) begin
      pc <= pc + XLEN'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (hs) req_pc <= pc;
  end

  // ---- IF/ID boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_instr <= NOP_INSTR;
    end else if (br_taken) begin
      if_valid <= 1'b0;
    end else if (load_en) begin
      if (skid_full) begin
        if_valid <= 1'b1;
        if_pc    <= skid_pc;
        if_instr <= skid_instr;
      end else if (live) begin
        if_valid <= 1'b1;
        if_pc    <= req_pc;
        if_instr <= imem_rdata;
      end else begin
        if_valid <= 1'b0;
      end
    end
  end

  fetch_skid_buffer #(.XLEN(XLEN)) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (skid_push),
    .pop        (skid_pop),
    .flush      (br_taken),
    .push_pc    (req_pc),
    .push_instr (imem_rdata),
    .full       (skid_full),
    .pc         (skid_pc),
    .instr      (skid_instr)
  );

  addr_stable_a: assert property (@(posedge clk) disable iff (!rst_n)
    (imem_req && !imem_gnt && !br_taken) |=> $stable(imem_addr));

  rvalid_state_a: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid |-> (state == ST_WAIT || state == ST_DRAIN));

endmodule
